// File: rtl/rand_client_if.sv
// Request/response and consumer-side signals of the random-number client.
// master = the client; slave = the server plus the local consumer.
interface rand_client_if;
  logic        REQ_WRITE;
  logic        REQ_WRITE_VALID;
  logic        REQ_WRITE_CONSUMED;
  logic [31:0] RESP_READ;
  logic        RESP_READ_VALID;
  logic        RESP_READ_CONSUMED;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;

  modport master (
    output REQ_WRITE, REQ_WRITE_VALID, RESP_READ_CONSUMED, OUT_DATA, OUT_VALID,
    input  REQ_WRITE_CONSUMED, RESP_READ, RESP_READ_VALID, OUT_READY
  );

  modport slave (
    input  REQ_WRITE, REQ_WRITE_VALID, RESP_READ_CONSUMED, OUT_DATA, OUT_VALID,
    output REQ_WRITE_CONSUMED, RESP_READ, RESP_READ_VALID, OUT_READY
  );
endinterface

// File: rtl/rand_client.sv
// Random-number client: fetches COUNT words from a rand server into a small FIFO
// and hands them to a consumer. Optional macro RAND_CLIENT_MASK_EN adds a MASK port.
//
// state | meaning
// IDLE  | waiting for START
// RUN   | issuing requests and draining words until COUNT have been popped
module rand_client #(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] COUNT,
  output logic             BUSY,
  output logic             DONE,
`ifdef RAND_CLIENT_MASK_EN
  input  logic [31:0]      MASK,
`endif
  rand_client_if.master    bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pend_q;
  logic [CNT_W-1:0]     req_left_q;
  logic [CNT_W-1:0]     out_left_q;
  logic [31:0]          mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q;
  logic [LOG_DEPTH-1:0] rd_ptr_q;
  logic [LOG_DEPTH:0]   cnt_q;
  logic [31:0]          hold_q;

  logic [LOG_DEPTH+1:0] inflight_d;
  logic                 req_valid_d;
  logic                 fire_d;
  logic                 push_d;
  logic                 pop_d;
  logic                 out_valid_d;
  logic [31:0]          head_d;
  logic [31:0]          push_data_d;
  logic                 unused_resp_valid;

  // Credits: words in the FIFO plus the one in flight must leave room for another.
  assign inflight_d  = {1'b0, cnt_q} + {{(LOG_DEPTH+1){1'b0}}, pend_q};
  assign req_valid_d = (state_q == RUN) && (req_left_q != '0) &&
                       (inflight_d < (LOG_DEPTH+2)'(DEPTH));
  assign fire_d      = req_valid_d & bus.REQ_WRITE_CONSUMED;
  assign push_d      = pend_q;
  assign out_valid_d = (cnt_q != '0);
  assign pop_d       = out_valid_d & bus.OUT_READY;
  assign head_d      = mem_q[rd_ptr_q];

`ifdef RAND_CLIENT_MASK_EN
  assign push_data_d = bus.RESP_READ & MASK;
`else
  assign push_data_d = bus.RESP_READ;
`endif

  assign unused_resp_valid      = bus.RESP_READ_VALID;
  assign bus.REQ_WRITE_VALID    = req_valid_d;
  assign bus.REQ_WRITE          = fire_d;
  assign bus.RESP_READ_CONSUMED = pend_q;
  assign bus.OUT_VALID          = out_valid_d;
  assign bus.OUT_DATA           = out_valid_d ? head_d : hold_q;
  assign BUSY                   = busy_q;
  assign DONE                   = done_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      req_left_q <= '0;
      out_left_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
    end else begin
      done_q <= 1'b0;
      pend_q <= fire_d;

      if (push_d) begin
        mem_q[wr_ptr_q] <= push_data_d;
        wr_ptr_q        <= wr_ptr_q + LOG_DEPTH'(1);
      end
      if (pop_d)
        rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(1);
      // OUT_DATA falls back to the last head once the FIFO drains.
      if (out_valid_d)
        hold_q <= head_d;

      case ({push_d, pop_d})
        2'b10:   cnt_q <= cnt_q + (LOG_DEPTH+1)'(1);
        2'b01:   cnt_q <= cnt_q - (LOG_DEPTH+1)'(1);
        default: cnt_q <= cnt_q;
      endcase

      case (state_q)
        IDLE: begin
          if (START) begin
            if (COUNT != '0) begin
              state_q    <= RUN;
              busy_q     <= 1'b1;
              req_left_q <= COUNT;
              out_left_q <= COUNT;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire_d)
            req_left_q <= req_left_q - CNT_W'(1);
          if (pop_d) begin
            out_left_q <= out_left_q - CNT_W'(1);
            if (out_left_q == CNT_W'(1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rand_client.md
Name: rand_client

Overview:
- Requester end of the random-number request/response interface: issues REQ_WRITE requests to a 32-bit random server and captures each RESP_READ word.
- Fetches a START-programmed number of words, buffers them in a small FIFO and hands them to a local consumer over valid/ready.
- Sits between a rand server instance and a stimulus/test engine; request credits guarantee the FIFO can never overflow.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2
- LOG_DEPTH, 2, log2(DEPTH)
- CNT_W, 16, width of COUNT and the internal counters

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  synchronous active-high reset
- START  in  1  one-cycle pulse; begin a transfer of COUNT words
- COUNT  in  CNT_W  words to fetch; sampled when START is accepted
- BUSY  out  1  high from START acceptance until DONE
- DONE  out  1  one-cycle pulse when the transfer completes
- REQ_WRITE  out  1  request fire strobe (REQ_WRITE_VALID & REQ_WRITE_CONSUMED)
- REQ_WRITE_VALID  out  1  client wants to issue a request
- REQ_WRITE_CONSUMED  in  1  server accepts the request this cycle
- RESP_READ  in  32  server random word
- RESP_READ_VALID  in  1  unused; kept for interface compatibility
- RESP_READ_CONSUMED  out  1  client captures RESP_READ this cycle
- OUT_DATA  out  32  FIFO head word
- OUT_VALID  out  1  FIFO non-empty
- OUT_READY  in  1  consumer pops the head when OUT_VALID & OUT_READY

Behaviour:
- Reset (sync, RST=1 at posedge) has priority over everything, including mid-transfer. After reset:
  - BUSY, DONE, REQ_WRITE_VALID, RESP_READ_CONSUMED and OUT_VALID are 0.
  - OUT_DATA is 0 and the FIFO is empty.
  - pend, req_left and out_left are 0; state is IDLE.
  - REQ_WRITE is 0 (combinational from REQ_WRITE_VALID).
- States: IDLE, RUN.
- IDLE, START=1 and COUNT>0: go to RUN, set BUSY=1, req_left=COUNT, out_left=COUNT.
- IDLE, START=1 and COUNT=0: stay IDLE, BUSY stays 0, DONE pulses on the next cycle.
- START while BUSY is ignored and COUNT is not resampled.
- Request issue:
  - REQ_WRITE_VALID = RUN & req_left!=0 & (fifo_count + pend) < DEPTH. It is combinational from registers only, never from REQ_WRITE_CONSUMED.
  - Fire = REQ_WRITE_VALID & REQ_WRITE_CONSUMED. On fire, req_left decrements and pend is set for the next cycle.
- Response:
  - The server updates RESP_READ at the fire edge, so the word is valid in the cycle after fire.
  - RESP_READ_CONSUMED = pend. While pend=1, RESP_READ is pushed into the FIFO at the next edge.
  - pend clears unless a new fire occurs in the same cycle. Back-to-back fires give one capture per cycle.
- FIFO:
  - Circular buffer with LOG_DEPTH-bit pointers that wrap naturally; occupancy counter is LOG_DEPTH+1 bits.
  - Simultaneous push and pop keeps the count unchanged.
  - The credit rule makes push-when-full impossible; a push into a full FIFO is a design error.
  - OUT_DATA = mem[rd_ptr] while OUT_VALID, otherwise it holds its last value.
- Completion:
  - Each pop (OUT_VALID & OUT_READY) decrements out_left.
  - The pop that takes out_left 1->0 moves the state to IDLE at that edge; BUSY is 0 and DONE=1 in the following cycle.
  - A new START is accepted in the DONE cycle.
- Latency: from the first fire to that word at OUT_VALID is 2 cycles (fire, capture, visible).
- Server stall (REQ_WRITE_CONSUMED=0): requests are held, no counters change. Consumer stall: fires stop once fifo_count + pend = DEPTH.
- Reset mid-transfer drops pending data and FIFO contents; no DONE is issued.

Optional Feature:
- Macro: RAND_CLIENT_MASK_EN.
- Defined: adds input port MASK [31:0]. The FIFO stores RESP_READ & MASK, so the consumer gets bounded values, e.g. MASK=0x0000_00FF gives 0..255. MASK is sampled at capture time.
- Undefined: no MASK port; the full 32-bit word is stored unmodified.

Test Plan:
- Reset then idle: RST high 2 cycles, then low with no START -> all outputs 0, no REQ_WRITE for 20 cycles.
- Basic transfer: server model seed=0, REQ_WRITE_CONSUMED=1, OUT_READY=1, START with COUNT=5 -> exactly 5 REQ_WRITE pulses. OUT_DATA sequence equals the model's first 5 $random(seed=0) words. BUSY for the whole run, DONE exactly once, 1 cycle after the 5th pop.
- Consumer stall: COUNT=10, OUT_READY=0 -> exactly DEPTH=4 fires, then REQ_WRITE_VALID=0 with FIFO full. Release OUT_READY -> remaining 6 words arrive in order and DONE pulses once.
- Server stall plus simultaneous push/pop: COUNT=8, REQ_WRITE_CONSUMED toggling 1,0,1,0 with OUT_READY=1 -> 8 words in order, fifo_count never exceeds 4, no lost or duplicated word.
- Boundary cases:
  - START with COUNT=0 -> no requests, DONE 1 cycle later, BUSY stays 0.
  - START during BUSY -> ignored; the run completes with the original COUNT.
- Reset mid-run: COUNT=6, assert RST after the 3rd capture -> all outputs 0 next cycle, no DONE. A new START with COUNT=2 completes normally.
- With RAND_CLIENT_MASK_EN: MASK=0xFF, COUNT=4 -> every OUT_DATA < 256 and equals the model word & 0xFF.
